// File: rtl/fp_align_shift_16_if.sv
// -----------------------------------------------------------------------------
// fp_align_shift_16_if
//   Handshake and data bundle for the mantissa alignment shifter.
//
//   Upstream side : in_valid, in_ready, mant, shamt
//   Downstream    : out_valid, out_ready, mant_o, guard_o, sticky_o, zero_o
//                   (+ round_o when FP_ALIGN_ROUND_BIT_EN is defined)
//
//   Modports:
//     slave  - the shifter itself (consumes beats, produces results)
//     master - the environment driving beats in and accepting results
//
//   Optional build macro: FP_ALIGN_ROUND_BIT_EN adds the round_o signal.
// -----------------------------------------------------------------------------
interface fp_align_shift_16_if #(
    parameter int W  = 16,
    parameter int SW = $clog2(W) + 1
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  mant;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  mant_o;
    logic          guard_o;
    logic          sticky_o;
    logic          zero_o;
`ifdef FP_ALIGN_ROUND_BIT_EN
    logic          round_o;
`endif

    modport slave (
        input  in_valid,
        output in_ready,
        input  mant,
        input  shamt,
        output out_valid,
        input  out_ready,
        output mant_o,
        output guard_o,
        output sticky_o,
        output zero_o
`ifdef FP_ALIGN_ROUND_BIT_EN
        , output round_o
`endif
    );

    modport master (
        output in_valid,
        input  in_ready,
        output mant,
        output shamt,
        input  out_valid,
        output out_ready,
        input  mant_o,
        input  guard_o,
        input  sticky_o,
        input  zero_o
`ifdef FP_ALIGN_ROUND_BIT_EN
        , input round_o
`endif
    );
endinterface

// File: rtl/fp_align_shift_16.sv
// -----------------------------------------------------------------------------
// fp_align_shift_16
//   Two-stage pipelined right shifter that aligns the smaller mantissa in the
//   FP adder.  Stage 1 applies the coarse (multiple-of-8) part of the shift,
//   stage 2 the residual 0..7 bits, then forms guard / sticky / zero.
//
//   Ports:
//     clk    - single clock, rising edge
//     rst_n  - asynchronous active-low reset
//     flush  - synchronous pipeline clear (drops in-flight and offered beats)
//     bus    - fp_align_shift_16_if.slave:
//                in_valid/in_ready/mant/shamt    upstream beat
//                out_valid/out_ready             downstream handshake
//                mant_o   = mant >> shamt
//                guard_o  = first bit shifted out below the LSB
//                sticky_o = OR of every shifted-out bit below guard
//                zero_o   = mant_o is all zeros
//
//   Optional build macro: FP_ALIGN_ROUND_BIT_EN
//     Adds round_o (the bit just below guard); sticky_o then covers only the
//     bits below round.  Without it the round bit folds into sticky_o.
//
//   Datapath trick: the mantissa is placed in the top half of a 2W-bit word
//   ({mant, W zeros}).  After shifting, the top half is the result, bit W-1 is
//   guard, bit W-2 is round and everything lower feeds sticky.  Bits pushed
//   off the bottom of the 2W window are accumulated separately per stage.
// -----------------------------------------------------------------------------
module fp_align_shift_16 #(
    parameter int W  = 16,
    parameter int SW = $clog2(W) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    fp_align_shift_16_if.slave   bus
);

    localparam int XW = 2 * W;

    // OR of all bits of v strictly below position n.
    function automatic logic or_below(input logic [XW-1:0] v, input int n);
        logic r;
        r = 1'b0;
        for (int i = 0; i < XW; i++) begin
            r = r | (v[i] & (i < n));
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic v1_r;
    logic v2_r;
    logic adv2_s;
    logic in_ready_s;
    logic ld1_s;
    logic ld2_s;

    // Stage advance / accept decisions; in_ready never looks at in_valid.
    always_comb begin
        adv2_s     = bus.out_ready | ~v2_r;
        in_ready_s = flush | ~v1_r | adv2_s;
        ld1_s      = bus.in_valid & in_ready_s & ~flush;
        ld2_s      = v1_r & adv2_s & ~flush;
    end

    // ------------------------------------------------------------------
    // Stage 1: coarse shift by shamt rounded down to a multiple of 8
    // ------------------------------------------------------------------
    logic [XW-1:0] full_s;
    logic [SW-1:0] coarse_s;
    logic [31:0]   shamt_x_s;
    logic          ovf_s;
    logic [XW-1:0] ext_s;
    logic          pst_s;

    logic [XW-1:0] ext1_r;
    logic          pst1_r;
    logic [2:0]    fine1_r;
    logic          ovf1_r;

    // Coarse shift of the widened mantissa plus OR of bits that fall off.
    always_comb begin
        full_s    = {bus.mant, {W{1'b0}}};
        coarse_s  = {bus.shamt[SW-1:3], 3'b000};
        shamt_x_s = 32'(bus.shamt);
        ovf_s     = (shamt_x_s >= 32'(XW));
        if (ovf_s) begin
            // Everything shifts out: nothing left, all of mant is sticky.
            ext_s = {XW{1'b0}};
            pst_s = |bus.mant;
        end else begin
            ext_s = full_s >> coarse_s;
            pst_s = or_below(full_s, int'(coarse_s));
        end
    end

    // Stage-1 valid and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            ext1_r  <= {XW{1'b0}};
            pst1_r  <= 1'b0;
            fine1_r <= 3'd0;
            ovf1_r  <= 1'b0;
        end else if (flush) begin
            v1_r <= 1'b0;
        end else begin
            if (~v1_r | adv2_s) begin
                v1_r <= bus.in_valid;
            end
            if (ld1_s) begin
                ext1_r  <= ext_s;
                pst1_r  <= pst_s;
                fine1_r <= bus.shamt[2:0];
                ovf1_r  <= ovf_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: fine shift by shamt[2:0], then guard / round / sticky / zero
    // ------------------------------------------------------------------
    logic [XW-1:0] fine_s;
    logic          dropf_s;
    logic [W-1:0]  mant2_s;
    logic          guard_s;
    logic          sticky_s;
    logic          zero_s;
`ifdef FP_ALIGN_ROUND_BIT_EN
    logic          round_s;
`endif

    logic [W-1:0]  mant2_r;
    logic          guard_r;
    logic          sticky_r;
    logic          zero_r;
`ifdef FP_ALIGN_ROUND_BIT_EN
    logic          round_r;
`endif

    // Residual shift and rounding-bit extraction from the widened word.
    always_comb begin
        fine_s  = ext1_r >> fine1_r;
        dropf_s = or_below(ext1_r, int'(fine1_r));
        if (ovf1_r) begin
            mant2_s  = {W{1'b0}};
            guard_s  = 1'b0;
            sticky_s = pst1_r;
`ifdef FP_ALIGN_ROUND_BIT_EN
            round_s  = 1'b0;
`endif
        end else begin
            mant2_s  = fine_s[XW-1:W];
            guard_s  = fine_s[W-1];
`ifdef FP_ALIGN_ROUND_BIT_EN
            round_s  = fine_s[W-2];
            sticky_s = pst1_r | dropf_s | (|fine_s[W-3:0]);
`else
            sticky_s = pst1_r | dropf_s | (|fine_s[W-2:0]);
`endif
        end
        zero_s = ~|mant2_s;
    end

    // Stage-2 valid and result registers; these drive the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r     <= 1'b0;
            mant2_r  <= {W{1'b0}};
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            zero_r   <= 1'b1;
`ifdef FP_ALIGN_ROUND_BIT_EN
            round_r  <= 1'b0;
`endif
        end else if (flush) begin
            v2_r <= 1'b0;
        end else begin
            if (adv2_s) begin
                v2_r <= v1_r;
            end
            if (ld2_s) begin
                mant2_r  <= mant2_s;
                guard_r  <= guard_s;
                sticky_r <= sticky_s;
                zero_r   <= zero_s;
`ifdef FP_ALIGN_ROUND_BIT_EN
                round_r  <= round_s;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = v2_r;
    assign bus.mant_o    = mant2_r;
    assign bus.guard_o   = guard_r;
    assign bus.sticky_o  = sticky_r;
    assign bus.zero_o    = zero_r;
`ifdef FP_ALIGN_ROUND_BIT_EN
    assign bus.round_o   = round_r;
`endif

endmodule
